// File: rtl/uart_byte_tx.sv
// uart_byte_tx: 8N1/8N2 serial transmitter (start, 8 data LSB first, optional even parity under UART_BYTE_TX_PARITY_EN, stop); ports clk, rst, tx_byte, transmit -> tx_serial, is_transmitting, tx_done
module uart_byte_tx #(
  parameter logic [15:0] CLKS_PER_BIT = 16'd868,
  parameter int STOP_BITS = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       transmit,
  output logic       tx_serial,
  output logic       is_transmitting,
  output logic       tx_done
);
`ifdef UART_BYTE_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  logic parity;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state;
  logic [15:0] baud;
  logic [2:0] bit_cnt;
  logic stop_cnt;
  logic [7:0] shreg;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      baud <= '0;
      bit_cnt <= '0;
      stop_cnt <= '0;
      shreg <= '0;
      tx_serial <= 1'b1;
      is_transmitting <= 1'b0;
      tx_done <= 1'b0;
`ifdef UART_BYTE_TX_PARITY_EN
      parity <= 1'b0;
`endif
    end else begin
      tx_done <= 1'b0;
      if (state == IDLE) begin
        if (transmit) begin
          shreg <= tx_byte;
          state <= START;
          tx_serial <= 1'b0;
          is_transmitting <= 1'b1;
          baud <= '0;
          bit_cnt <= '0;
          stop_cnt <= '0;
`ifdef UART_BYTE_TX_PARITY_EN
          parity <= ^tx_byte;
`endif
        end
      end else if (baud != CLKS_PER_BIT - 16'd1) begin
        baud <= baud + 16'd1;
      end else begin
        baud <= '0;
        case (state)
          START: begin
            state <= DATA;
            tx_serial <= shreg[0];
          end
          DATA: begin
            bit_cnt <= bit_cnt + 3'd1;
            shreg <= {1'b0, shreg[7:1]};
            if (bit_cnt == 3'd7) begin
`ifdef UART_BYTE_TX_PARITY_EN
              state <= PARITY;
              tx_serial <= parity;
`else
              state <= STOP;
              tx_serial <= 1'b1;
`endif
            end else begin
              tx_serial <= shreg[1];
            end
          end
`ifdef UART_BYTE_TX_PARITY_EN
          PARITY: begin
            state <= STOP;
            tx_serial <= 1'b1;
          end
`endif
          STOP: begin
            if (stop_cnt == 1'(STOP_BITS - 1)) begin
              state <= IDLE;
              is_transmitting <= 1'b0;
              tx_done <= 1'b1;
            end else begin
              stop_cnt <= stop_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_byte_tx.sv
// tb_uart_byte_tx: frame-trace checks of uart_byte_tx against a bit-list frame model
module tb_uart_byte_tx;
  logic clk = 1'b0;
  logic rst, t0, t1;
  logic [7:0] tx_byte;
  logic s0, b0, d0, s1, b1, d1;
  int total = 0;
  int passed = 0;
`ifdef UART_BYTE_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  localparam int L0 = 4 * (10 + PB);
  localparam int L1 = 3 * (11 + PB);

  uart_byte_tx #(.CLKS_PER_BIT(16'd4), .STOP_BITS(1)) u0 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .transmit(t0),
    .tx_serial(s0), .is_transmitting(b0), .tx_done(d0));
  uart_byte_tx #(.CLKS_PER_BIT(16'd3), .STOP_BITS(2)) u1 (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .transmit(t1),
    .tx_serial(s1), .is_transmitting(b1), .tx_done(d1));

  always #5 clk = ~clk;

  typedef struct {
    int w;
    logic [7:0] b;
    int poke;
    int ra;
    int len;
  } vec_t;

  task automatic chk(input string nm, input logic [0:255] a, input logic [0:255] e);
    total++;
    if (a !== e) $display("FAIL %s: got %0h expected %0h", nm, a, e);
    else passed++;
  endtask

  task automatic model(input int w, input logic [7:0] b, input int ra,
                       output logic [0:255] es, output logic [0:255] eb, output logic [0:255] ed, output int n);
    int cpb;
    int sb;
    bit q[$];
    cpb = (w == 1) ? 3 : 4;
    sb = (w == 1) ? 2 : 1;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(b[i]);
`ifdef UART_BYTE_TX_PARITY_EN
    q.push_back(^b);
`endif
    repeat (sb) q.push_back(1'b1);
    n = q.size() * cpb;
    es = '1;
    eb = '0;
    ed = '0;
    for (int k = 0; k < n; k++) begin
      es[k] = q[k / cpb];
      eb[k] = 1'b1;
    end
    ed[n] = 1'b1;
    if (ra >= 0)
      for (int k = ra + 1; k < 256; k++) begin
        es[k] = 1'b1;
        eb[k] = 1'b0;
        ed[k] = 1'b0;
      end
  endtask

  task automatic run(input int w, input logic [7:0] b, input int poke, input int ra, input int nc,
                     output logic [0:255] gs, output logic [0:255] gb, output logic [0:255] gd);
    gs = '1;
    gb = '0;
    gd = '0;
    tx_byte = b;
    if (w == 1) t1 = 1'b1; else t0 = 1'b1;
    @(posedge clk); #1;
    t0 = 1'b0; t1 = 1'b0;
    tx_byte = 8'($urandom);
    for (int k = 0; k < nc; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
        t0 = 1'b0; t1 = 1'b0; rst = 1'b0;
      end
      gs[k] = (w == 1) ? s1 : s0;
      gb[k] = (w == 1) ? b1 : b0;
      gd[k] = (w == 1) ? d1 : d0;
      if (k == poke) begin
        tx_byte = 8'hFF;
        if (w == 1) t1 = 1'b1; else t0 = 1'b1;
      end
      if (k == ra) rst = 1'b1;
    end
  endtask

  task automatic frame(input string nm, input int w, input logic [7:0] b, input int poke, input int ra,
                       input int len, input bit b2b);
    logic [0:255] es, eb, ed, gs, gb, gd;
    int n;
    model(w, b, ra, es, eb, ed, n);
    run(w, b, poke, ra, b2b ? n + 1 : n + 3, gs, gb, gd);
    chk({nm, " ser"}, gs, es);
    chk({nm, " busy"}, gb, eb);
    chk({nm, " done"}, gd, ed);
    chk({nm, " len"}, 256'($countones(gb)), 256'(len));
  endtask

  initial begin
    vec_t v[$];
    logic [0:255] es, eb, ed, gs, gb, gd;
    int n;
    v.push_back('{0, 8'h55, -1, -1, L0});
    v.push_back('{0, 8'h00, 10, -1, L0});
    v.push_back('{0, 8'hA5, -1, 15, 16});
    v.push_back('{0, 8'h5A, -1, -1, L0});
    v.push_back('{1, 8'h3C, -1, -1, L1});
    v.push_back('{1, 8'hFF, -1, -1, L1});
    v.push_back('{0, 8'h07, -1, -1, L0});
    rst = 1'b1; t0 = 1'b0; t1 = 1'b0; tx_byte = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("rst ser0", 256'(s0), 256'(1));
    chk("rst busy0", 256'(b0), 256'(0));
    chk("rst done0", 256'(d0), 256'(0));
    chk("rst ser1", 256'(s1), 256'(1));
    chk("rst busy1", 256'(b1), 256'(0));
    chk("rst done1", 256'(d1), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    foreach (v[i]) frame($sformatf("v%0d", i), v[i].w, v[i].b, v[i].poke, v[i].ra, v[i].len, 1'b0);
    frame("b2b first", 0, 8'h80, -1, -1, L0, 1'b1);
    frame("b2b second", 0, 8'h01, -1, -1, L0, 1'b0);
`ifdef UART_BYTE_TX_PARITY_EN
    model(0, 8'h07, -1, es, eb, ed, n);
    run(0, 8'h07, -1, -1, n + 3, gs, gb, gd);
    chk("parity bit", 256'(gs[36]), 256'(1));
`endif
    rst = 1'b1; t0 = 1'b1; tx_byte = 8'h99;
    @(posedge clk); #1;
    rst = 1'b0; t0 = 1'b0;
    chk("rst+tx busy", 256'(b0), 256'(0));
    chk("rst+tx ser", 256'(s0), 256'(1));
    @(posedge clk); #1;
    chk("rst+tx later busy", 256'(b0), 256'(0));
    for (int r = 0; r < 20; r++) begin
      int w;
      bit bb;
      logic [7:0] b;
      w = $urandom_range(0, 1);
      b = 8'($urandom);
      bb = 1'($urandom);
      frame($sformatf("rnd%0d", r), w, b, -1, -1, w == 1 ? L1 : L0, bb);
      if (bb) frame($sformatf("rnd%0d b2b", r), w, ~b, -1, -1, w == 1 ? L1 : L0, 1'b0);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #1;
      end
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
